// File: rtl/sram_2p_pkg.sv
// Shared types and March C- element table for the two-port SRAM model.
// Element table is bit-indexed by element number (M0 = bit 0 .. M5 = bit 5):
//   EL_UP      address walks 0 -> DEPTH-1 when set, DEPTH-1 -> 0 otherwise
//   EL_HAS_RD  element starts each address with a read
//   EL_HAS_WR  element ends each address with a write
//   EL_RD_VAL  background expected by the read (0 = all zeros, 1 = all ones)
//   EL_WR_VAL  background written
package sram_2p_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    M0    = 4'd1,
    M1    = 4'd2,
    M2    = 4'd3,
    M3    = 4'd4,
    M4    = 4'd5,
    M5    = 4'd6,
    FLUSH = 4'd7,
    DONE  = 4'd8
  } march_state_e;

  localparam int unsigned MARCH_OPS_PER_WORD = 10;

  localparam logic [5:0] EL_UP     = 6'b000111;
  localparam logic [5:0] EL_HAS_RD = 6'b111110;
  localparam logic [5:0] EL_HAS_WR = 6'b011111;
  localparam logic [5:0] EL_RD_VAL = 6'b010100;
  localparam logic [5:0] EL_WR_VAL = 6'b001010;

  // Element number of a march state; only meaningful for M0..M5.
  function automatic logic [2:0] el_idx(input march_state_e s);
    logic [3:0] d;
    d = 4'(s) - 4'(M0);
    return d[2:0];
  endfunction

  // Operations per address in an element (1 or 2).
  function automatic logic [1:0] el_ops(input logic [2:0] e);
    return 2'(EL_HAS_RD[e]) + 2'(EL_HAS_WR[e]);
  endfunction

endpackage

// File: rtl/sram_2p_march_ctrl.sv
// March C- BIST controller for sram_2p_march_bist. Built only when
// SRAM_2P_MARCH_BIST_EN is defined.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   start_i             start request (ignored while busy)
//   rd_word_i           array word at ov_addr_o (combinational from the array)
//   ov_we_o             port-A write override
//   ov_addr_o           port-A address override
//   ov_wval_o           background bit to replicate across the write word
//   busy_o, done_o      run status
//   fail_o, fail_addr_o sticky mismatch flag and first failing address
//
// state | meaning
// IDLE  | waiting for start
// M0    | up,   w0
// M1    | up,   r0 then w1 per address
// M2    | up,   r1 then w0 per address
// M3    | down, r0 then w1 per address
// M4    | down, r1 then w0 per address
// M5    | down, r0
// FLUSH | compare of the last M5 read
// DONE  | finished, flags held until start or reset
`ifdef SRAM_2P_MARCH_BIST_EN
module sram_2p_march_ctrl
  import sram_2p_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] rd_word_i,
  output logic              ov_we_o,
  output logic [ADDR_W-1:0] ov_addr_o,
  output logic              ov_wval_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  march_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;

  logic              in_el;
  logic [2:0]        el;
  logic              el_up, el_rd, el_wr;
  logic              op_rd, op_last, at_end;

  always_comb begin
    in_el   = (state_q inside {M0, M1, M2, M3, M4, M5});
    el      = in_el ? el_idx(state_q) : 3'd0;
    el_up   = EL_UP[el];
    el_rd   = EL_HAS_RD[el];
    el_wr   = EL_HAS_WR[el];
    // Reads always come first in an r,w pair.
    op_rd   = in_el && el_rd && !phase_q;
    op_last = (el_ops(el) == 2'd1) || phase_q;
    at_end  = el_up ? (addr_q == ADDR_LAST) : (addr_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = M0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      M0, M1, M2, M3, M4, M5: begin
        if (!op_last) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (at_end) begin
            // M5 + 1 is FLUSH; the next element's start address comes
            // from its direction, never from counter overflow.
            state_d = march_state_e'(4'(state_q) + 4'd1);
            if (state_q == M5) addr_d = '0;
            else addr_d = EL_UP[el + 3'd1] ? '0 : ADDR_LAST;
          end else begin
            addr_d = el_up ? addr_q + 1'b1 : addr_q - 1'b1;
          end
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = in_el || (state_q == FLUSH);
    done_o    = (state_q == DONE);
    ov_we_o   = in_el && el_wr && (phase_q || !el_rd);
    ov_addr_o = addr_q;
    ov_wval_o = EL_WR_VAL[el];
  end

  // Read data is registered with its expected background and address,
  // then compared in the following cycle.
  logic              cmp_vld_q, cmp_exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic              mismatch, start_ok;

  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch = cmp_vld_q && (rdata_q != {DATA_W{cmp_exp_q}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= '0;
      rdata_q     <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      cmp_vld_q <= op_rd;
      if (op_rd) begin
        cmp_exp_q  <= EL_RD_VAL[el];
        cmp_addr_q <= addr_q;
        rdata_q    <= rd_word_i;
      end
      if (start_ok) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
      end else if (mismatch && !fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= cmp_addr_q;
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;

endmodule
`endif

// File: rtl/sram_2p_march_bist.sv
// Two-port synchronous SRAM model with per-bit write mask and optional
// March C- BIST (compiled in with `define SRAM_2P_MARCH_BIST_EN).
// Ports:
//   CLK, RST                   shared clock, async active-high reset
//   A_/B_ MEN, WEN, REN        port enable, write enable, read enable
//   A_/B_ ADDR, DIN, BM        word address, write data, bit mask (1 = write)
//   A_/B_ DOUT                 registered read data, holds without a read
//   BIST_START                 start request
//   BIST_BUSY, BIST_DONE       engine status
//   BIST_FAIL, BIST_FAIL_ADDR  sticky fail flag and first failing address
// Same-address write collision: port A owns bits where A_BM=1, port B the rest.
module sram_2p_march_bist
  import sram_2p_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_MEN,
  input  logic              A_WEN,
  input  logic              A_REN,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DIN,
  input  logic [DATA_W-1:0] A_BM,
  output logic [DATA_W-1:0] A_DOUT,
  input  logic              B_MEN,
  input  logic              B_WEN,
  input  logic              B_REN,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DIN,
  input  logic [DATA_W-1:0] B_BM,
  output logic [DATA_W-1:0] B_DOUT,
  input  logic              BIST_START,
  output logic              BIST_BUSY,
  output logic              BIST_DONE,
  output logic              BIST_FAIL,
  output logic [ADDR_W-1:0] BIST_FAIL_ADDR
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              bist_busy;
  logic              ov_we;
  logic [ADDR_W-1:0] ov_addr;
  logic              ov_wval;

`ifdef SRAM_2P_MARCH_BIST_EN
  sram_2p_march_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk_i       (CLK),
    .rst_i       (RST),
    .start_i     (BIST_START),
    .rd_word_i   (mem_q[ov_addr]),
    .ov_we_o     (ov_we),
    .ov_addr_o   (ov_addr),
    .ov_wval_o   (ov_wval),
    .busy_o      (bist_busy),
    .done_o      (BIST_DONE),
    .fail_o      (BIST_FAIL),
    .fail_addr_o (BIST_FAIL_ADDR)
  );
`else
  logic bist_start_unused;
  assign bist_start_unused = BIST_START;
  assign bist_busy         = 1'b0;
  assign ov_we             = 1'b0;
  assign ov_addr           = '0;
  assign ov_wval           = 1'b0;
  assign BIST_DONE         = 1'b0;
  assign BIST_FAIL         = 1'b0;
  assign BIST_FAIL_ADDR    = '0;
`endif

  assign BIST_BUSY = bist_busy;

  // Port A is taken over by the engine while it runs; port B is silenced.
  logic              a_we, a_re, b_we, b_re;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din, a_bm;
  logic [DATA_W-1:0] a_base, a_wdata, b_wdata;

  always_comb begin
    a_we   = bist_busy ? ov_we : (A_MEN && A_WEN);
    a_addr = bist_busy ? ov_addr : A_ADDR;
    a_din  = bist_busy ? {DATA_W{ov_wval}} : A_DIN;
    a_bm   = bist_busy ? {DATA_W{1'b1}} : A_BM;
    a_re   = !bist_busy && A_MEN && A_REN;
    b_we   = !bist_busy && B_MEN && B_WEN;
    b_re   = !bist_busy && B_MEN && B_REN;

    b_wdata = (mem_q[B_ADDR] & ~B_BM) | (B_DIN & B_BM);
    // On a same-address collision port A merges on top of port B's result,
    // so B's bits survive wherever A_BM=0.
    a_base  = (b_we && (B_ADDR == a_addr)) ? b_wdata : mem_q[a_addr];
    a_wdata = (a_base & ~a_bm) | (a_din & a_bm);
  end

  always_ff @(posedge CLK) begin
    if (b_we) mem_q[B_ADDR] <= b_wdata;
    if (a_we) mem_q[a_addr] <= a_wdata;
  end

  logic [DATA_W-1:0] a_dout_q, b_dout_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      if (a_re) a_dout_q <= mem_q[A_ADDR];
      if (b_re) b_dout_q <= mem_q[B_ADDR];
    end
  end

  assign A_DOUT = a_dout_q;
  assign B_DOUT = b_dout_q;

endmodule

// File: doc/sram_2p_march_bist.md
# sram_2p_march_bist

Parametrised two-port synchronous SRAM model for the sg13g2 SRAM macro library, generalised in data width and depth. Both ports share one clock and support per-bit write masking. An integrated March C- BIST engine tests the whole array autonomously and reports pass/fail plus the first failing address. The model is used in RTL simulation of DFT flows in place of fixed-size macro models.

## Interface
Parameters:
- DATA_W, 32, word width in bits (1..128)
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words

Ports:
- Clocking: one clock, CLK; reset RST is asynchronous and active-high.
- CLK  in  1  clock for both ports and the BIST engine
- RST  in  1  asynchronous active-high reset
- A_MEN / B_MEN  in  1  port enable
- A_WEN / B_WEN  in  1  write enable (qualified by MEN)
- A_REN / B_REN  in  1  read enable (qualified by MEN)
- A_ADDR / B_ADDR  in  ADDR_W  word address
- A_DIN / B_DIN  in  DATA_W  write data
- A_BM / B_BM  in  DATA_W  bit mask; 1 = bit written
- A_DOUT / B_DOUT  out  DATA_W  registered read data
- BIST_START  in  1  single-cycle start request
- BIST_BUSY  out  1  engine running
- BIST_DONE  out  1  run finished; held until next start or reset
- BIST_FAIL  out  1  sticky mismatch flag
- BIST_FAIL_ADDR  out  ADDR_W  address of the first mismatch

## Operation
- Write: on posedge CLK with MEN&&WEN, mem[ADDR][i] <= DIN[i] for every i with BM[i]=1.
- Read: on posedge CLK with MEN&&REN, DOUT <= mem[ADDR]. Without a read, DOUT holds its value.
- WEN&&REN on the same port: the write is performed and DOUT returns the old word (read-before-write).
- Cross-port read/write to the same address in the same cycle: the read returns the old word.
- Both ports write the same address in the same cycle: port A wins on every bit where A_BM=1. Port B's bits apply only where A_BM=0.
- BIST uses port A internally. Background 0 = all zeros, background 1 = all ones. Sequence:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇓(r0)
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE.
  - IDLE/DONE → M0 on BIST_START.
  - Each element walks the address from 0 to DEPTH-1 (⇑) or from DEPTH-1 to 0 (⇓), one op per cycle. r,w pairs use two cycles per address.
  - After M5's last read the FSM goes to FLUSH for one compare cycle, then to DONE.
- Compare: the read data is registered and compared one cycle later against the expected background. The first mismatch sets BIST_FAIL and latches BIST_FAIL_ADDR. Later mismatches do not update BIST_FAIL_ADDR.
- While BIST_BUSY=1: all functional port inputs are ignored (no writes, no reads), and A_DOUT/B_DOUT hold their values.
- BIST_START while BUSY is ignored. BIST_START in DONE clears FAIL/FAIL_ADDR/DONE and restarts.
- Memory contents after BIST end at all zeros (M4 writes 0, M5 only reads).

## Timing
- Reset values: A_DOUT=0, B_DOUT=0, BIST_BUSY=0, BIST_DONE=0, BIST_FAIL=0, BIST_FAIL_ADDR=0, FSM=IDLE. Array contents are not reset.
- Read latency is 1 cycle: data is visible after the capturing edge.
- BIST_START sampled high at edge k → BUSY=1 from edge k.
- BUSY stays high for exactly 10·DEPTH+1 cycles; DONE rises at the same edge BUSY falls. DEPTH=256 gives 2561 cycles.
- RST mid-BIST: immediate return to IDLE and all flags cleared. The partially written array is left as-is.
- The address counter wraps via explicit terminal-count compare, never by overflow into the next element.

## Configuration
- SRAM_2P_MARCH_BIST_EN defined: the BIST engine is compiled in as described above.
- Undefined: no BIST logic is built. BIST_START is ignored; BIST_BUSY, BIST_DONE and BIST_FAIL are tied 0; BIST_FAIL_ADDR is tied 0. Functional ports are never blocked.

## Structure
- Package sram_2p_pkg holds:
  - march_state_e (IDLE, M0..M5, FLUSH, DONE)
  - per-element constants: direction, read-expect value, write value, op count
  - MARCH_OPS_PER_WORD = 10
- Sub-module sram_2p_march_ctrl contains the FSM, the up/down address counter, the expected-data pipeline register and the comparator. It drives an internal port-A override bus.
- The top level holds the array, the port logic, the collision resolution and the override mux.

## Test plan
- A write 0xDEADBEEF @0x10 with BM=0xFFFF0000, then A read @0x10 → A_DOUT[31:16]=0xDEAD, low half unchanged, valid 1 cycle after the read edge.
- A write 0x11111111 and B write 0x22222222 @0x20 in the same cycle, both BM=all-ones → subsequent read = 0x11111111. With A_BM=0x0000FFFF instead → 0x22221111.
- B read @0x30 in the same cycle A writes 0xA5A5A5A5 there → B_DOUT = old word; next B read → 0xA5A5A5A5.
- Clean array, pulse BIST_START → BUSY high for 2561 cycles, DONE=1, FAIL=0; functional writes attempted during the run have no effect; array reads 0 afterwards.
- Force bit 5 of word 0x3C stuck-at-1, run BIST → FAIL=1 and FAIL_ADDR=0x3C; the first detection occurs in M1 (r0).
- Assert RST at cycle 700 of a BIST run → BUSY/DONE/FAIL all 0 immediately. A new BIST_START completes normally in 2561 cycles.
